seg_disp_sched: RTL and testbench

//   Arbitrates two display requesters (switch input value, CPU/GCD result) for the 4-digit
//   7-segment driver. Converts the granted binary value to 4 BCD digits with a sequential

---
 rtl/seg_disp_sched_if.sv | 22 ++
 rtl/seg_disp_sched.sv | 85 ++++++++
 tb/tb_seg_disp_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_disp_sched_if.sv
// seg_disp_sched_if: requester handshake and display bus of the 7-segment scheduler
interface seg_disp_sched_if;
  logic        req_sw;
  logic [15:0] sw_val;
  logic        req_res;
  logic [31:0] res_val;
  logic        grant_sw;
  logic        grant_res;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        disp_src;
  logic [15:0] seg_data_16;
  modport master (
    output req_sw, sw_val, req_res, res_val,
    input  grant_sw, grant_res, busy, done, ovf, disp_src, seg_data_16
  );
  modport slave (
    input  req_sw, sw_val, req_res, res_val,
    output grant_sw, grant_res, busy, done, ovf, disp_src, seg_data_16
  );
endinterface

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: arbitrates switch/result display requests and converts to blanked BCD
module seg_disp_sched #(
  parameter bit LZ_BLANK = 1'b1,
  parameter bit RES_PRIO = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seg_disp_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t      state;
  logic [31:0] val;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [15:0] adj;
  logic [15:0] blanked;
  logic [3:0]  cnt;
  logic        src_n;
  logic        ovf_n;
  logic        pick_res;
  assign pick_res = bus.req_res && (RES_PRIO || !bus.req_sw);
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_comb begin
    blanked[3:0]   = bcd[3:0];
    blanked[7:4]   = (LZ_BLANK && bcd[15:4] == 12'd0) ? 4'hF : bcd[7:4];
    blanked[11:8]  = (LZ_BLANK && bcd[15:8] == 8'd0) ? 4'hF : bcd[11:8];
    blanked[15:12] = (LZ_BLANK && bcd[15:12] == 4'd0) ? 4'hF : bcd[15:12];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      val             <= '0;
      bin             <= '0;
      bcd             <= '0;
      cnt             <= '0;
      src_n           <= 1'b0;
      ovf_n           <= 1'b0;
      bus.grant_sw    <= 1'b0;
      bus.grant_res   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.ovf         <= 1'b0;
      bus.disp_src    <= 1'b0;
      bus.seg_data_16 <= LZ_BLANK ? 16'hFFF0 : 16'h0000;
    end else begin
      bus.grant_sw  <= 1'b0;
      bus.grant_res <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= bus.req_sw || bus.req_res;
          if (bus.req_sw || bus.req_res) begin
            bus.grant_res <= pick_res;
            bus.grant_sw  <= !pick_res;
            val           <= pick_res ? bus.res_val : {16'd0, bus.sw_val};
            src_n         <= pick_res;
            state         <= LOAD;
          end
        end
        LOAD: begin
          ovf_n <= val > 32'd9999;
          bin   <= val[13:0];
          bcd   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {adj[14:0], bin, 1'b0};
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd13) state <= DONE;
        end
        DONE: begin
          bus.seg_data_16 <= ovf_n ? 16'hFFFF : blanked;
          bus.ovf         <= ovf_n;
          bus.disp_src    <= src_n;
          bus.done        <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: two instances (blanking+result priority, plain+switch priority) vs a decimal model
module tb_seg_disp_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seg_disp_sched_if ba ();
  seg_disp_sched_if bb ();
  seg_disp_sched #(.LZ_BLANK(1'b1), .RES_PRIO(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  seg_disp_sched #(.LZ_BLANK(1'b0), .RES_PRIO(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
  logic        rq_sw [2];
  logic        rq_res[2];
  logic [15:0] sw_v;
  logic [31:0] res_v;
  logic        gs[2], gr[2], dn[2], bz[2], ov[2], sr[2];
  logic [15:0] sg[2];
  assign ba.req_sw = rq_sw[0];
  assign ba.req_res = rq_res[0];
  assign ba.sw_val = sw_v;
  assign ba.res_val = res_v;
  assign bb.req_sw = rq_sw[1];
  assign bb.req_res = rq_res[1];
  assign bb.sw_val = sw_v;
  assign bb.res_val = res_v;
  assign gs[0] = ba.grant_sw;
  assign gr[0] = ba.grant_res;
  assign dn[0] = ba.done;
  assign bz[0] = ba.busy;
  assign ov[0] = ba.ovf;
  assign sr[0] = ba.disp_src;
  assign sg[0] = ba.seg_data_16;
  assign gs[1] = bb.grant_sw;
  assign gr[1] = bb.grant_res;
  assign dn[1] = bb.done;
  assign bz[1] = bb.busy;
  assign ov[1] = bb.ovf;
  assign sr[1] = bb.disp_src;
  assign sg[1] = bb.seg_data_16;
  int total = 0;
  int bad = 0;
  logic [17:0] expq[2][$];
  int          cycq[2][$];
  logic [15:0] hold[2];
  // instance 0 blanks and favours the result requester; instance 1 does neither
  function automatic bit lz_of(input int d);
    return d == 0;
  endfunction
  // {disp_src, ovf, seg_data_16} from decimal digit arithmetic
  function automatic logic [17:0] model(input logic [31:0] v, input bit lz, input bit src);
    logic [15:0] s;
    logic [3:0]  dg;
    bit          nz;
    if (v > 32'd9999) return {src, 1'b1, 16'hFFFF};
    nz = 1'b0;
    s[3:0] = 4'(v % 10);
    for (int i = 3; i >= 1; i--) begin
      dg = 4'((v / (10 ** i)) % 10);
      nz = nz || (dg != 0);
      s[4*i +: 4] = (lz && !nz) ? 4'hF : dg;
    end
    return {src, 1'b0, s};
  endfunction
  task automatic xact(input bit rs, input bit rr, input logic [15:0] sv, input logic [31:0] rv);
    int need[2];
    int got[2];
    int last_g[2];
    int cyc;
    bit exp_res;
    logic [17:0] e;
    int c0;
    sw_v = sv;
    res_v = rv;
    for (int d = 0; d < 2; d++) begin
      rq_sw[d] = rs;
      rq_res[d] = rr;
      need[d] = int'(rs) + int'(rr);
      got[d] = 0;
      last_g[d] = -1;
      hold[d] = sg[d];
    end
    cyc = 0;
    while ((got[0] < need[0] || got[1] < need[1]) && cyc < 120) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (gs[d] || gr[d]) begin
          exp_res = rq_res[d] && (lz_of(d) || !rq_sw[d]);
          total++;
          if (gr[d] !== exp_res || gs[d] !== !exp_res) begin
            bad++;
            $display("FAIL grant_sel dut%0d: got sw=%b res=%b, want res=%b", d, gs[d], gr[d], exp_res);
          end
          if (last_g[d] >= 0) begin
            total++;
            if (cyc - last_g[d] != 17) begin
              bad++;
              $display("FAIL b2b_period dut%0d: got %0d, want 17", d, cyc - last_g[d]);
            end
          end
          last_g[d] = cyc;
          expq[d].push_back(model(gr[d] ? rv : {16'd0, sv}, lz_of(d), gr[d]));
          cycq[d].push_back(cyc);
          if (gr[d]) rq_res[d] = 1'b0;
          else rq_sw[d] = 1'b0;
        end
        if (dn[d]) begin
          got[d]++;
          total++;
          if (expq[d].size() == 0) begin
            bad++;
            $display("FAIL spurious_done dut%0d: got done, want none", d);
          end else begin
            e = expq[d].pop_front();
            c0 = cycq[d].pop_front();
            if ({sr[d], ov[d], sg[d]} !== e) begin
              bad++;
              $display("FAIL display dut%0d: got src=%b ovf=%b seg=%h, want src=%b ovf=%b seg=%h",
                       d, sr[d], ov[d], sg[d], e[17], e[16], e[15:0]);
            end
            total++;
            if (cyc - c0 != 16 || bz[d] !== 1'b1) begin
              bad++;
              $display("FAIL latency dut%0d: got %0d busy=%b, want 16 busy=1", d, cyc - c0, bz[d]);
            end
          end
          hold[d] = sg[d];
        end else if (bz[d] && sg[d] !== hold[d]) begin
          total++;
          bad++;
          $display("FAIL seg_stable dut%0d: got %h while busy, want %h", d, sg[d], hold[d]);
          hold[d] = sg[d];
        end
      end
    end
    total++;
    if (cyc >= 120) begin
      bad++;
      $display("FAIL timeout: got %0d/%0d and %0d/%0d done pulses", got[0], need[0], got[1], need[1]);
    end
    rq_sw[0] = 1'b0;
    rq_sw[1] = 1'b0;
    rq_res[0] = 1'b0;
    rq_res[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (bz[d] !== 1'b0 || dn[d] !== 1'b0 || expq[d].size() != 0) begin
        bad++;
        $display("FAIL settle dut%0d: got busy=%b done=%b pending=%0d, want 0 0 0", d, bz[d], dn[d], expq[d].size());
      end
      expq[d].delete();
      cycq[d].delete();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    sw_v = '0;
    res_v = '0;
    for (int d = 0; d < 2; d++) begin
      rq_sw[d] = 1'b0;
      rq_res[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({gs[d], gr[d], bz[d], dn[d], ov[d], sr[d], sg[d]} !== {6'b0, (d == 0) ? 16'hFFF0 : 16'h0000}) begin
        bad++;
        $display("FAIL reset dut%0d: got g=%b%b busy=%b done=%b ovf=%b src=%b seg=%h", d, gs[d], gr[d], bz[d], dn[d], ov[d], sr[d], sg[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_values();
    xact(1'b1, 1'b0, 16'd42, 32'd0);
    xact(1'b0, 1'b1, 16'd0, 32'd9999);
    xact(1'b0, 1'b1, 16'd0, 32'd10000);
    xact(1'b0, 1'b1, 16'd0, 32'd0);
    xact(1'b0, 1'b1, 16'd0, 32'd1005);
    xact(1'b1, 1'b0, 16'd7, 32'd0);
    xact(1'b1, 1'b0, 16'hFFFF, 32'd0);
    xact(1'b0, 1'b1, 16'd0, 32'h0001_0005);
    xact(1'b1, 1'b0, 16'd100, 32'd0);
  endtask
  task automatic test_back_to_back();
    xact(1'b1, 1'b1, 16'd1234, 32'd567);
    xact(1'b1, 1'b1, 16'd20000, 32'd9);
  endtask
  task automatic test_mid_reset();
    int cyc;
    int dones;
    sw_v = 16'd321;
    rq_sw[0] = 1'b1;
    rq_sw[1] = 1'b1;
    cyc = 0;
    while (!gs[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!(gs[0] && gs[1])) begin
      bad++;
      $display("FAIL mid_grant: got %b%b, want 11", gs[0], gs[1]);
    end
    rq_sw[0] = 1'b0;
    rq_sw[1] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      dones += int'(dn[0]) + int'(dn[1]);
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (sg[d] !== ((d == 0) ? 16'hFFF0 : 16'h0000) || bz[d] !== 1'b0 || ov[d] !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset dut%0d: got seg=%h busy=%b ovf=%b", d, sg[d], bz[d], ov[d]);
      end
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL mid_reset_done: got %0d pulses, want 0", dones);
    end
    xact(1'b1, 1'b0, 16'd321, 32'd0);
  endtask
  task automatic test_random();
    bit rs;
    bit rr;
    logic [31:0] rv;
    for (int n = 0; n < 20; n++) begin
      rs = 1'($urandom_range(0, 1));
      rr = rs ? 1'($urandom_range(0, 1)) : 1'b1;
      rv = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12000));
      xact(rs, rr, ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 10500)) : 16'($urandom), rv);
    end
  endtask
  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
